// File: rtl/display7_scan.sv
`default_nettype none
// ============================================================================
//  Module   : display7_scan
//  Brief    : Time-multiplexed common-anode 7-segment scanner with per-digit
//             decimal point, blanking and anode dead-time.
//  Revision : 1.0 - initial release
// ============================================================================
module display7_scan #(
    parameter int DIGITS  = 4,
    parameter int CLK_DIV = 50000,
    parameter int DEAD    = 2,
    parameter int HEX_EN  = 1
) (
    input  logic                  iClk,
    input  logic                  iRst_n,
    input  logic [4*DIGITS-1:0]   iData,
    input  logic [DIGITS-1:0]     iDp,
    input  logic [DIGITS-1:0]     iBlank,
    input  logic                  iLoad,
    output logic [6:0]            oSeg,
    output logic                  oDp,
    output logic [DIGITS-1:0]     oAn
);

    localparam int CNT_W = $clog2(CLK_DIV);
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [CNT_W-1:0] c_CNT_MAX = CNT_W'(CLK_DIV - 1);
    localparam logic [IDX_W-1:0] c_IDX_MAX = IDX_W'(DIGITS - 1);
    localparam logic [6:0]       c_SEG_OFF = 7'b1111111;

    // Snapshot registers
    logic [DIGITS-1:0][3:0] r_data;
    logic [DIGITS-1:0]      r_dp;
    logic [DIGITS-1:0]      r_blank;

    // Scan position
    logic [CNT_W-1:0]       r_cnt;
    logic [IDX_W-1:0]       r_idx;

    // Registered pin drivers
    logic [DIGITS-1:0]      r_an;
    logic [6:0]             r_seg;
    logic                   r_dp_out;

    logic                   w_dead;
    logic [3:0]             w_nib;
    logic                   w_dp_sel;
    logic                   w_blank_sel;
    logic [DIGITS-1:0]      w_an;
    logic [6:0]             w_seg;
    logic                   w_dp_out;

    // Active-low g..a glyphs; hex letters collapse to dark when HEX_EN=0.
    function automatic logic [6:0] f_decode(input logic [3:0] i_nib);
        logic [6:0] v_seg;
        v_seg = c_SEG_OFF;
        case (i_nib)
            4'h0: v_seg = 7'b1000000;
            4'h1: v_seg = 7'b1111001;
            4'h2: v_seg = 7'b0100100;
            4'h3: v_seg = 7'b0110000;
            4'h4: v_seg = 7'b0011001;
            4'h5: v_seg = 7'b0010010;
            4'h6: v_seg = 7'b0000010;
            4'h7: v_seg = 7'b1111000;
            4'h8: v_seg = 7'b0000000;
            4'h9: v_seg = 7'b0010000;
            4'hA: v_seg = (HEX_EN != 0) ? 7'b0001000 : c_SEG_OFF;
            4'hB: v_seg = (HEX_EN != 0) ? 7'b0000011 : c_SEG_OFF;
            4'hC: v_seg = (HEX_EN != 0) ? 7'b1000110 : c_SEG_OFF;
            4'hD: v_seg = (HEX_EN != 0) ? 7'b0100001 : c_SEG_OFF;
            4'hE: v_seg = (HEX_EN != 0) ? 7'b0000110 : c_SEG_OFF;
            4'hF: v_seg = (HEX_EN != 0) ? 7'b0001110 : c_SEG_OFF;
            default: v_seg = c_SEG_OFF;
        endcase
        return v_seg;
    endfunction

    // All three snapshot fields load on the same edge so a digit is never torn.
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            r_data  <= '0;
            r_dp    <= '0;
            r_blank <= '0;
        end else if (iLoad) begin
            r_data  <= iData;
            r_dp    <= iDp;
            r_blank <= iBlank;
        end
    end

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            r_cnt <= '0;
            r_idx <= '0;
        end else if (r_cnt == c_CNT_MAX) begin
            r_cnt <= '0;
            r_idx <= (r_idx == c_IDX_MAX) ? '0 : r_idx + 1'b1;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    generate
        if (DEAD > 0) begin : g_dead
            assign w_dead = (r_cnt < CNT_W'(DEAD));
        end else begin : g_no_dead
            assign w_dead = 1'b0;
        end
    endgenerate

    always_comb begin
        w_nib       = 4'h0;
        w_dp_sel    = 1'b0;
        w_blank_sel = 1'b0;
        for (int k = 0; k < DIGITS; k++) begin
            if (r_idx == IDX_W'(k)) begin
                w_nib       = r_data[k];
                w_dp_sel    = r_dp[k];
                w_blank_sel = r_blank[k];
            end
        end
    end

    // Anodes derive from a single index compare, so at most one is ever low.
    always_comb begin
        w_an     = '1;
        w_seg    = c_SEG_OFF;
        w_dp_out = 1'b1;
        if (!w_dead) begin
            for (int k = 0; k < DIGITS; k++) begin
                w_an[k] = (r_idx != IDX_W'(k));
            end
            if (!w_blank_sel) begin
                w_seg    = f_decode(w_nib);
                w_dp_out = ~w_dp_sel;
            end
        end
    end

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            r_an     <= '1;
            r_seg    <= c_SEG_OFF;
            r_dp_out <= 1'b1;
        end else begin
            r_an     <= w_an;
            r_seg    <= w_seg;
            r_dp_out <= w_dp_out;
        end
    end

    assign oAn  = r_an;
    assign oSeg = r_seg;
    assign oDp  = r_dp_out;

endmodule
`default_nettype wire

// File: tb/tb_display7_scan.sv
`default_nettype none
// ============================================================================
//  Module   : tb_display7_scan
//  Brief    : Bench for display7_scan; three parameterisations share stimulus
//             and are checked every cycle against a scan-position model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_display7_scan;

    logic        clk;
    logic        rst_n;
    logic        iLoad;
    logic [15:0] iData;
    logic [3:0]  iDp;
    logic [3:0]  iBlank;

    logic [6:0]  seg_a, seg_b, seg_c;
    logic        dp_a, dp_b, dp_c;
    logic [3:0]  an_a, an_b;
    logic [2:0]  an_c;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state: edges since reset release and the snapshot
    int          p;
    logic [15:0] s_data;
    logic [3:0]  s_dp;
    logic [3:0]  s_bl;
    logic [6:0]  ref_seg [16];

    display7_scan #(.DIGITS(4), .CLK_DIV(4), .DEAD(1), .HEX_EN(1)) u_dut_a (
        .iClk(clk), .iRst_n(rst_n), .iData(iData), .iDp(iDp), .iBlank(iBlank),
        .iLoad(iLoad), .oSeg(seg_a), .oDp(dp_a), .oAn(an_a)
    );

    display7_scan #(.DIGITS(4), .CLK_DIV(4), .DEAD(1), .HEX_EN(0)) u_dut_b (
        .iClk(clk), .iRst_n(rst_n), .iData(iData), .iDp(iDp), .iBlank(iBlank),
        .iLoad(iLoad), .oSeg(seg_b), .oDp(dp_b), .oAn(an_b)
    );

    display7_scan #(.DIGITS(3), .CLK_DIV(3), .DEAD(0), .HEX_EN(1)) u_dut_c (
        .iClk(clk), .iRst_n(rst_n), .iData(iData[11:0]), .iDp(iDp[2:0]),
        .iBlank(iBlank[2:0]), .iLoad(iLoad), .oSeg(seg_c), .oDp(dp_c), .oAn(an_c)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got {an,seg,dp}=%h expected %h", tag, $time, obs, exp);
        end
    endtask

    // Expected pins after the edge that follows scan position pos.
    // Packed as {an[7:0] (unused digits 1), seg[6:0], dp}.
    function automatic logic [15:0] model(input int nd, input int div, input int dead,
                                          input bit hex, input int pos,
                                          input logic [15:0] d, input logic [3:0] dpv,
                                          input logic [3:0] blv);
        int         cnt;
        int         idx;
        logic [3:0] nib;
        logic [7:0] an;
        logic [6:0] seg;
        logic       odp;
        cnt = pos % div;
        idx = (pos / div) % nd;
        if (cnt < dead) return 16'hFFFF;
        an      = 8'hFF;
        an[idx] = 1'b0;
        nib     = d[idx*4 +: 4];
        if (blv[idx]) begin
            seg = 7'h7F;
            odp = 1'b1;
        end else begin
            seg = (!hex && nib > 4'd9) ? 7'h7F : ref_seg[nib];
            odp = ~dpv[idx];
        end
        return {an, seg, odp};
    endfunction

    task automatic check_all(input string phase, input logic [15:0] ea,
                             input logic [15:0] eb, input logic [15:0] ec);
        chk({phase, "/hex4"},   {4'hF, an_a, seg_a, dp_a}, ea);
        chk({phase, "/nohex4"}, {4'hF, an_b, seg_b, dp_b}, eb);
        chk({phase, "/dig3"},   {5'h1F, an_c, seg_c, dp_c}, ec);
    endtask

    // Drives inputs, takes one clock edge and checks all DUTs at the next negedge.
    task automatic step(input logic ld, input logic [15:0] d,
                        input logic [3:0] dpv, input logic [3:0] blv);
        logic [15:0] ea, eb, ec;
        iLoad  = ld;
        iData  = d;
        iDp    = dpv;
        iBlank = blv;
        @(posedge clk);
        if (rst_n) begin
            ea = model(4, 4, 1, 1'b1, p, s_data, s_dp, s_bl);
            eb = model(4, 4, 1, 1'b0, p, s_data, s_dp, s_bl);
            ec = model(3, 3, 0, 1'b1, p, s_data, s_dp, s_bl);
            if (ld) begin
                s_data = d;
                s_dp   = dpv;
                s_bl   = blv;
            end
            p++;
        end else begin
            ea = 16'hFFFF;
            eb = 16'hFFFF;
            ec = 16'hFFFF;
        end
        @(negedge clk);
        check_all("scan", ea, eb, ec);
    endtask

    // Asserts reset between edges, checks the outputs went dark with no edge,
    // holds it across two edges and releases between edges.
    task automatic do_reset();
        #2;
        rst_n  = 1'b0;
        s_data = '0;
        s_dp   = '0;
        s_bl   = '0;
        p      = 0;
        #1;
        check_all("async_rst", 16'hFFFF, 16'hFFFF, 16'hFFFF);
        step(1'b1, 16'h8888, 4'hF, 4'h0);
        step(1'b0, 16'h8888, 4'hF, 4'h0);
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish, n_vec=%0d expected completion", n_vec);
        $fatal(1, "timeout");
    end

    initial begin
        ref_seg[0]  = 7'b1000000; ref_seg[1]  = 7'b1111001;
        ref_seg[2]  = 7'b0100100; ref_seg[3]  = 7'b0110000;
        ref_seg[4]  = 7'b0011001; ref_seg[5]  = 7'b0010010;
        ref_seg[6]  = 7'b0000010; ref_seg[7]  = 7'b1111000;
        ref_seg[8]  = 7'b0000000; ref_seg[9]  = 7'b0010000;
        ref_seg[10] = 7'b0001000; ref_seg[11] = 7'b0000011;
        ref_seg[12] = 7'b1000110; ref_seg[13] = 7'b0100001;
        ref_seg[14] = 7'b0000110; ref_seg[15] = 7'b0001110;

        rst_n  = 1'b1;
        iLoad  = 1'b0;
        iData  = '0;
        iDp    = '0;
        iBlank = '0;
        p      = 0;
        s_data = '0;
        s_dp   = '0;
        s_bl   = '0;

        @(negedge clk);
        do_reset();

        // First slot and scan order
        step(1'b1, 16'h4321, 4'h0, 4'h0);
        repeat (20) step(1'b0, 16'h4321, 4'h0, 4'h0);

        // Hex letters (dark on the HEX_EN=0 instance)
        step(1'b1, 16'hFEDA, 4'h0, 4'h0);
        repeat (16) step(1'b0, 16'hFEDA, 4'h0, 4'h0);
        step(1'b1, 16'hCB98, 4'h0, 4'h0);
        repeat (16) step(1'b0, 16'hCB98, 4'h0, 4'h0);

        // Decimal point on digit 1, digit 3 blanked with dp also requested
        step(1'b1, 16'h5678, 4'b1010, 4'b1000);
        repeat (16) step(1'b0, 16'h5678, 4'b1010, 4'b1000);

        // Load mid-slot while digit 2 is active, then input churn without load
        while (p % 16 != 10) step(1'b0, 16'h5678, 4'b1010, 4'b1000);
        step(1'b1, 16'h0000, 4'h0, 4'h0);
        repeat (18) step(1'b0, 16'h9999, 4'hF, 4'hF);

        // Async reset with the scan at cnt=2, idx=3
        while (p % 16 != 14) step(1'b0, 16'h7777, 4'h0, 4'h0);
        do_reset();
        repeat (20) step(1'b0, 16'hABCD, 4'hF, 4'h0);

        // Randomised traffic with occasional mid-scan resets
        repeat (500) begin
            if ($urandom_range(0, 149) == 0) begin
                do_reset();
            end else begin
                step($urandom_range(0, 3) == 0, 16'($urandom), 4'($urandom),
                     4'($urandom) & 4'($urandom));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
